ahb_gpio_irq: RTL and testbench

Parametrised AHB-Lite GPIO controller and successor to the fixed 32-pin GPIO block. Adds:
- configurable pin count and input synchroniser depth
- atomic set/clear/toggle of the output register
- per-pin level/edge interrupt detection with write-1-to-clear status and a single masked IRQ line

Sits on the peripheral AHB segment. Pad and alternate-function muxing stay outside the block.

---
 rtl/gpio_pkg.sv | 41 ++++
 rtl/ahb_gpio_irq_if.sv | 24 ++
 rtl/gpio_irq_detect.sv | 54 +++++
 rtl/ahb_gpio_irq.sv | 165 ++++++++++++++++
 tb/tb_ahb_gpio_irq.sv | 321 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the AHB-Lite GPIO controller: register offsets,
// byte-lane mask generation and byte-lane merge helpers.
package gpio_pkg;

  localparam logic [31:0] OFF_DO    = 32'h00;
  localparam logic [31:0] OFF_DI    = 32'h04;
  localparam logic [31:0] OFF_DIR   = 32'h08;
  localparam logic [31:0] OFF_AFC   = 32'h0C;
  localparam logic [31:0] OFF_DOSET = 32'h10;
  localparam logic [31:0] OFF_DOCLR = 32'h14;
  localparam logic [31:0] OFF_DOTGL = 32'h18;
  localparam logic [31:0] OFF_IE    = 32'h1C;
  localparam logic [31:0] OFF_ITYPE = 32'h20;
  localparam logic [31:0] OFF_IPOL  = 32'h24;
  localparam logic [31:0] OFF_IBOTH = 32'h28;
  localparam logic [31:0] OFF_ISTAT = 32'h2C;
  localparam logic [31:0] OFF_IPEND = 32'h30;

  // HSIZE 010 and above all count as a full word.
  function automatic logic [3:0] lane_mask(input logic [2:0] hsize, input logic [1:0] addr);
    logic [3:0] m;
    case (hsize)
      3'b000:  m = 4'b0001 << addr;
      3'b001:  m = addr[1] ? 4'b1100 : 4'b0011;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] wdata,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (mask[b]) res[8*b +: 8] = wdata[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ahb_gpio_irq_if.sv
// AHB-Lite slave-side signal bundle. Handshake: an address phase is taken when
// HSEL & HREADY & HTRANS[1]; the slave never stalls (HREADYOUT=1, HRESP=OKAY).
interface ahb_gpio_irq_if #(parameter int ADDR_W = 8);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic              HREADYOUT;
  logic              HRESP;
  logic [31:0]       HRDATA;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/gpio_irq_detect.sv
// Pad synchroniser plus per-pin interrupt status: live level compare or
// sticky edge capture with write-1-to-clear.
module gpio_irq_detect #(
  parameter int GPIO_W      = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [GPIO_W-1:0] gpio_di,
  input  logic [GPIO_W-1:0] itype,
  input  logic [GPIO_W-1:0] itype_rise,
  input  logic [GPIO_W-1:0] ipol,
  input  logic [GPIO_W-1:0] iboth,
  input  logic [GPIO_W-1:0] clr,
  output logic [GPIO_W-1:0] di_sync,
  output logic [GPIO_W-1:0] istat
);

  logic [GPIO_W-1:0] sync_q [SYNC_STAGES];
  logic [GPIO_W-1:0] sync_d [SYNC_STAGES];
  logic [GPIO_W-1:0] prev_q, prev_d;
  logic [GPIO_W-1:0] istat_q, istat_d;
  logic [GPIO_W-1:0] s, rise, fall, edge_hit, level_hit;

  always_comb begin
    sync_d[0] = gpio_di;
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    s         = sync_q[SYNC_STAGES-1];
    prev_d    = s;
    rise      = s & ~prev_q;
    fall      = ~s & prev_q;
    edge_hit  = (iboth & (rise | fall)) | (~iboth & ipol & rise) | (~iboth & ~ipol & fall);
    level_hit = ~(s ^ ipol);
    // A fresh edge in the same cycle as a clear keeps the bit set.
    istat_d   = ~itype_rise & ((~itype & level_hit) |
                               (itype & (edge_hit | (istat_q & ~clr))));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q  <= '0;
      istat_q <= '0;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= sync_d[i];
      prev_q  <= prev_d;
      istat_q <= istat_d;
    end
  end

  assign di_sync = s;
  assign istat   = istat_q;

endmodule

// File: rtl/ahb_gpio_irq.sv
// AHB-Lite GPIO controller: bus decode, register file, atomic DO updates and
// a single registered, masked interrupt line.
module ahb_gpio_irq
  import gpio_pkg::*;
#(
  parameter int GPIO_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int ADDR_W      = 8
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  ahb_gpio_irq_if.slave     ahb,
  input  logic [GPIO_W-1:0] GPIO_DI,
  output logic [GPIO_W-1:0] GPIO_DO,
  output logic [GPIO_W-1:0] GPIO_DIR,
  output logic [GPIO_W-1:0] GPIO_AFC,
  output logic              IRQ
);

  logic              valid_q, valid_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [3:0]        mask_q, mask_d;

  logic [GPIO_W-1:0] do_q, do_d, dir_q, dir_d, afc_q, afc_d, ie_q, ie_d;
  logic [GPIO_W-1:0] itype_q, itype_d, ipol_q, ipol_d, iboth_q, iboth_d;
  logic              irq_q, irq_d;

  logic              accept, wr_en;
  logic [31:0]       reg_off, wr_lanes, cur, merged, rdata;
  logic [GPIO_W-1:0] wdat_g, mg, itype_rise, istat_clr, di_sync, istat;

  always_comb begin
    accept  = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    valid_d = accept;
    write_d = write_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    if (accept) begin
      write_d = ahb.HWRITE;
      addr_d  = ahb.HADDR[ADDR_W-1:0];
      mask_d  = lane_mask(ahb.HSIZE, ahb.HADDR[1:0]);
    end
  end

  always_comb begin
    reg_off  = 32'(addr_q) & 32'hFFFF_FFFC;
    wr_en    = valid_q & write_q;
    wr_lanes = byte_merge(32'h0, ahb.HWDATA, mask_q);
    wdat_g   = wr_lanes[GPIO_W-1:0];

    cur = 32'h0;
    case (reg_off)
      OFF_DO:    cur = 32'(do_q);
      OFF_DIR:   cur = 32'(dir_q);
      OFF_AFC:   cur = 32'(afc_q);
      OFF_IE:    cur = 32'(ie_q);
      OFF_ITYPE: cur = 32'(itype_q);
      OFF_IPOL:  cur = 32'(ipol_q);
      OFF_IBOTH: cur = 32'(iboth_q);
      default:   cur = 32'h0;
    endcase
    merged = byte_merge(cur, ahb.HWDATA, mask_q);
    mg     = merged[GPIO_W-1:0];

    do_d      = do_q;
    dir_d     = dir_q;
    afc_d     = afc_q;
    ie_d      = ie_q;
    itype_d   = itype_q;
    ipol_d    = ipol_q;
    iboth_d   = iboth_q;
    istat_clr = '0;
    if (wr_en) begin
      case (reg_off)
        OFF_DO:    do_d      = mg;
        OFF_DOSET: do_d      = do_q | wdat_g;
        OFF_DOCLR: do_d      = do_q & ~wdat_g;
        OFF_DOTGL: do_d      = do_q ^ wdat_g;
        OFF_DIR:   dir_d     = mg;
        OFF_AFC:   afc_d     = mg;
        OFF_IE:    ie_d      = mg;
        OFF_ITYPE: itype_d   = mg;
        OFF_IPOL:  ipol_d    = mg;
        OFF_IBOTH: iboth_d   = mg;
        OFF_ISTAT: istat_clr = wdat_g;
        default:   ;
      endcase
    end
    // Level-to-edge switch starts the pin with a clean status bit.
    itype_rise = itype_d & ~itype_q;
    irq_d      = |(istat & ie_q);
  end

  always_comb begin
    case (reg_off)
      OFF_DO:    rdata = 32'(do_q);
      OFF_DI:    rdata = 32'(di_sync);
      OFF_DIR:   rdata = 32'(dir_q);
      OFF_AFC:   rdata = 32'(afc_q);
      OFF_IE:    rdata = 32'(ie_q);
      OFF_ITYPE: rdata = 32'(itype_q);
      OFF_IPOL:  rdata = 32'(ipol_q);
      OFF_IBOTH: rdata = 32'(iboth_q);
      OFF_ISTAT: rdata = 32'(istat);
      OFF_IPEND: rdata = 32'(istat & ie_q);
      default:   rdata = 32'h0;
    endcase
    ahb.HRDATA = (valid_q & ~write_q) ? rdata : 32'h0;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      valid_q <= 1'b0;
      write_q <= 1'b0;
      addr_q  <= '0;
      mask_q  <= '0;
      do_q    <= '0;
      dir_q   <= '0;
      afc_q   <= '0;
      ie_q    <= '0;
      itype_q <= '0;
      ipol_q  <= '0;
      iboth_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      write_q <= write_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
      do_q    <= do_d;
      dir_q   <= dir_d;
      afc_q   <= afc_d;
      ie_q    <= ie_d;
      itype_q <= itype_d;
      ipol_q  <= ipol_d;
      iboth_q <= iboth_d;
      irq_q   <= irq_d;
    end
  end

  gpio_irq_detect #(
    .GPIO_W      (GPIO_W),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_detect (
    .clk        (HCLK),
    .rst_n      (HRESETn),
    .gpio_di    (GPIO_DI),
    .itype      (itype_q),
    .itype_rise (itype_rise),
    .ipol       (ipol_q),
    .iboth      (iboth_q),
    .clr        (istat_clr),
    .di_sync    (di_sync),
    .istat      (istat)
  );

  assign ahb.HREADYOUT = 1'b1;
  assign ahb.HRESP     = 1'b0;
  assign GPIO_DO       = do_q;
  assign GPIO_DIR      = dir_q;
  assign GPIO_AFC      = afc_q;
  assign IRQ           = irq_q;

endmodule

// File: tb/tb_ahb_gpio_irq.sv
// Bench for ahb_gpio_irq: a 32-pin and an 8-pin instance driven in lockstep,
// directed steps followed by random traffic checked against a register model.
module tb_ahb_gpio_irq;

  localparam logic [7:0] A_DO = 8'h00, A_DI = 8'h04, A_DIR = 8'h08, A_AFC = 8'h0C;
  localparam logic [7:0] A_DOSET = 8'h10, A_DOCLR = 8'h14, A_DOTGL = 8'h18, A_IE = 8'h1C;
  localparam logic [7:0] A_ITYPE = 8'h20, A_IPOL = 8'h24, A_IBOTH = 8'h28;
  localparam logic [7:0] A_ISTAT = 8'h2C, A_IPEND = 8'h30;

  logic        HCLK = 1'b0;
  logic        HRESETn = 1'b0;
  logic [31:0] pads = 32'h0;

  always #5 HCLK = ~HCLK;

  ahb_gpio_irq_if #(.ADDR_W(8)) b32 ();
  ahb_gpio_irq_if #(.ADDR_W(8)) b8 ();

  logic [31:0] do32, dir32, afc32;
  logic [7:0]  do8, dir8, afc8;
  logic        irq32, irq8;

  ahb_gpio_irq #(.GPIO_W(32), .SYNC_STAGES(2), .ADDR_W(8)) dut32 (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(b32), .GPIO_DI(pads),
    .GPIO_DO(do32), .GPIO_DIR(dir32), .GPIO_AFC(afc32), .IRQ(irq32));

  ahb_gpio_irq #(.GPIO_W(8), .SYNC_STAGES(2), .ADDR_W(8)) dut8 (
    .HCLK(HCLK), .HRESETn(HRESETn), .ahb(b8), .GPIO_DI(pads[7:0]),
    .GPIO_DO(do8), .GPIO_DIR(dir8), .GPIO_AFC(afc8), .IRQ(irq8));

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state (32-pin view; the 8-pin view is the low byte)
  logic [31:0] m_do, m_dir, m_afc, m_ie, m_itype, m_ipol, m_iboth, m_istat, m_pad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus(input logic act, input logic wr, input logic [2:0] size, input logic [7:0] addr);
    b32.HSEL = act; b32.HTRANS = act ? 2'b10 : 2'b00; b32.HWRITE = wr;
    b32.HSIZE = size; b32.HADDR = addr; b32.HREADY = 1'b1;
    b8.HSEL = act;  b8.HTRANS = act ? 2'b10 : 2'b00;  b8.HWRITE = wr;
    b8.HSIZE = size;  b8.HADDR = addr;  b8.HREADY = 1'b1;
  endtask

  task automatic wdata(input logic [31:0] d);
    b32.HWDATA = d;
    b8.HWDATA  = d;
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [2:0] size, input logic [31:0] d);
    bus(1'b1, 1'b1, size, addr);
    tick();
    bus(1'b0, 1'b0, 3'd0, 8'h0);
    wdata(d);
    tick();
  endtask

  task automatic rd(input logic [7:0] addr, input logic [2:0] size,
                    output logic [31:0] d32, output logic [31:0] d8);
    bus(1'b1, 1'b0, size, addr);
    tick();
    bus(1'b0, 1'b0, 3'd0, 8'h0);
    @(negedge HCLK);
    d32 = b32.HRDATA;
    d8  = b8.HRDATA;
    chk("ready_resp", {28'h0, b32.HREADYOUT, b8.HREADYOUT, b32.HRESP, b8.HRESP}, 32'hC);
  endtask

  task automatic model_reset();
    m_do = 0; m_dir = 0; m_afc = 0; m_ie = 0; m_itype = 0; m_ipol = 0; m_iboth = 0;
    m_pad = pads;
    m_istat = ~(m_pad ^ m_ipol);
  endtask

  task automatic model_write(input logic [7:0] addr, input logic [2:0] size, input logic [31:0] d);
    logic [31:0] wm, eff, newt;
    int a;
    bit en;
    a  = int'(addr);
    wm = 0;
    for (int b = 0; b < 4; b++) begin
      if (size == 3'd0)      en = (b == a % 4);
      else if (size == 3'd1) en = (b / 2 == (a / 2) % 2);
      else                   en = 1'b1;
      if (en) wm = wm | (32'hFF << (8 * b));
    end
    eff = d & wm;
    case (addr & 8'hFC)
      A_DO:    m_do  = (m_do & ~wm) | eff;
      A_DOSET: m_do  = m_do | eff;
      A_DOCLR: m_do  = m_do & ~eff;
      A_DOTGL: m_do  = m_do ^ eff;
      A_DIR:   m_dir = (m_dir & ~wm) | eff;
      A_AFC:   m_afc = (m_afc & ~wm) | eff;
      A_IE:    m_ie  = (m_ie & ~wm) | eff;
      A_IPOL:  m_ipol  = (m_ipol & ~wm) | eff;
      A_IBOTH: m_iboth = (m_iboth & ~wm) | eff;
      A_ITYPE: begin
        newt    = (m_itype & ~wm) | eff;
        m_istat = m_istat & ~(newt & ~m_itype);
        m_itype = newt;
      end
      A_ISTAT: m_istat = m_istat & ~(eff & m_itype);
      default: ;
    endcase
    m_istat = (m_istat & m_itype) | (~m_itype & ~(m_pad ^ m_ipol));
  endtask

  task automatic model_pads(input logic [31:0] nw);
    logic [31:0] rise, fall, qual;
    rise    = ~m_pad & nw;
    fall    = m_pad & ~nw;
    qual    = (m_iboth & (rise | fall)) | (~m_iboth & m_ipol & rise) | (~m_iboth & ~m_ipol & fall);
    m_istat = m_istat | (qual & m_itype);
    m_pad   = nw;
    m_istat = (m_istat & m_itype) | (~m_itype & ~(m_pad ^ m_ipol));
  endtask

  function automatic logic [31:0] model_read(input logic [7:0] off);
    case (off)
      A_DO:    return m_do;
      A_DI:    return m_pad;
      A_DIR:   return m_dir;
      A_AFC:   return m_afc;
      A_IE:    return m_ie;
      A_ITYPE: return m_itype;
      A_IPOL:  return m_ipol;
      A_IBOTH: return m_iboth;
      A_ISTAT: return m_istat;
      A_IPEND: return m_istat & m_ie;
      default: return 32'h0;
    endcase
  endfunction

  initial begin
    logic [31:0] d32, d8, data, nw;
    logic [7:0]  off, addr;
    logic [2:0]  size;
    int          r;

    // 1: reset values
    bus(1'b0, 1'b0, 3'd0, 8'h0);
    wdata(32'h0);
    repeat (3) @(posedge HCLK);
    @(negedge HCLK);
    chk("rst_outputs", do32 | dir32 | afc32 | {31'h0, irq32}, 32'h0);
    HRESETn = 1'b1;
    repeat (3) tick();
    for (int o = 0; o <= 'h30; o += 4) begin
      rd(8'(o), 3'd2, d32, d8);
      chk($sformatf("reset_rd_%02h", o), d32, (8'(o) == A_ISTAT) ? 32'hFFFF_FFFF : 32'h0);
    end
    chk("reset_irq", {31'h0, irq32}, 32'h0);

    // 2: lane writes
    wr(A_DO, 3'd2, 32'h0000_FFFF);
    wr(8'h01, 3'd0, 32'h0000_A500);
    wr(8'h02, 3'd1, 32'h1234_0000);
    rd(A_DO, 3'd2, d32, d8);
    chk("lane_do", d32, 32'h1234_A5FF);
    chk("lane_pin", do32, 32'h1234_A5FF);

    // 3: atomic set/clear/toggle
    wr(A_DO, 3'd2, 32'hF0F0_F0F0);
    wr(A_DOSET, 3'd2, 32'h0000_000F);
    rd(A_DO, 3'd2, d32, d8);
    chk("doset", d32, 32'hF0F0_F0FF);
    wr(A_DOCLR, 3'd2, 32'hF000_0000);
    rd(A_DO, 3'd2, d32, d8);
    chk("doclr", d32, 32'h00F0_F0FF);
    wr(A_DOTGL, 3'd2, 32'hFFFF_FFFF);
    rd(A_DO, 3'd2, d32, d8);
    chk("dotgl", d32, 32'hFF0F_0F00);
    rd(A_DOSET, 3'd2, d32, d8);
    chk("doset_reads0", d32, 32'h0);

    // 4: rising edge interrupt timing on pin 3
    wr(A_IPOL, 3'd2, 32'hFFFF_FFFF);
    wr(A_ITYPE, 3'd2, 32'h8);
    wr(A_IE, 3'd2, 32'h8);
    repeat (2) tick();
    rd(A_ISTAT, 3'd2, d32, d8);
    chk("edge_idle_istat", d32, 32'h0);
    tick();
    pads[3] = 1'b1;
    bus(1'b1, 1'b0, 3'd2, A_ISTAT);
    for (int k = 1; k <= 4; k++) begin
      @(posedge HCLK);
      @(negedge HCLK);
      chk($sformatf("edge_istat_t%0d", k), b32.HRDATA, (k >= 3) ? 32'h8 : 32'h0);
      chk($sformatf("edge_irq_t%0d", k), {31'h0, irq32}, (k >= 4) ? 32'h1 : 32'h0);
    end
    bus(1'b0, 1'b0, 3'd0, 8'h0);
    wr(A_ISTAT, 3'd2, 32'h8);
    @(negedge HCLK);
    chk("w1c_irq_hold", {31'h0, irq32}, 32'h1);
    @(posedge HCLK);
    @(negedge HCLK);
    chk("w1c_irq_drop", {31'h0, irq32}, 32'h0);

    // 5: set beats clear on an edge pin
    pads[3] = 1'b0;
    repeat (6) tick();
    rd(A_ISTAT, 3'd2, d32, d8);
    chk("fall_ignored", d32, 32'h0);
    tick();
    pads[3] = 1'b1;
    tick();
    bus(1'b1, 1'b1, 3'd2, A_ISTAT);
    tick();
    bus(1'b0, 1'b0, 3'd0, 8'h0);
    wdata(32'h8);
    tick();
    rd(A_ISTAT, 3'd2, d32, d8);
    chk("set_beats_clr", d32, 32'h8);
    wr(A_ISTAT, 3'd2, 32'h8);
    rd(A_ISTAT, 3'd2, d32, d8);
    chk("w1c_clears", d32, 32'h0);

    // 5: level pin 5, active low
    wr(A_IPOL, 3'd2, 32'hFFFF_FFDF);
    repeat (3) tick();
    rd(A_ISTAT, 3'd2, d32, d8);
    chk("level_low", d32, 32'h20);
    wr(A_ISTAT, 3'd2, 32'h20);
    repeat (2) tick();
    rd(A_ISTAT, 3'd2, d32, d8);
    chk("level_w1c_noop", d32, 32'h20);
    tick();
    pads[5] = 1'b1;
    bus(1'b1, 1'b0, 3'd2, A_ISTAT);
    for (int k = 1; k <= 4; k++) begin
      @(posedge HCLK);
      @(negedge HCLK);
      chk($sformatf("level_drop_t%0d", k), b32.HRDATA, (k >= 3) ? 32'h0 : 32'h20);
    end
    bus(1'b0, 1'b0, 3'd0, 8'h0);

    // 6: narrow instance, unmapped read, back-to-back, reset mid-write
    wr(A_DO, 3'd2, 32'hFFFF_FFFF);
    rd(A_DO, 3'd2, d32, d8);
    chk("w32_do", d32, 32'hFFFF_FFFF);
    chk("w8_do", d8, 32'h0000_00FF);
    chk("w8_pin", {24'h0, do8}, 32'hFF);
    rd(8'h40, 3'd2, d32, d8);
    chk("unmapped_rd", d32 | d8, 32'h0);
    bus(1'b1, 1'b1, 3'd2, A_DIR);
    tick();
    bus(1'b1, 1'b0, 3'd2, A_DIR);
    wdata(32'h0000_A5A5);
    tick();
    bus(1'b0, 1'b0, 3'd0, 8'h0);
    @(negedge HCLK);
    chk("b2b_rd32", b32.HRDATA, 32'h0000_A5A5);
    chk("b2b_rd8", b8.HRDATA, 32'h0000_00A5);
    pads = 32'h0;
    tick();
    bus(1'b1, 1'b1, 3'd2, A_DO);
    tick();
    bus(1'b0, 1'b0, 3'd0, 8'h0);
    wdata(32'h1234_5678);
    #2 HRESETn = 1'b0;
    #1;
    chk("rst_async32", do32 | dir32 | {31'h0, irq32}, 32'h0);
    chk("rst_async8", {16'h0, do8, dir8}, 32'h0);
    @(negedge HCLK);
    HRESETn = 1'b1;
    model_reset();
    repeat (3) tick();
    rd(A_DO, 3'd2, d32, d8);
    chk("rst_abort_do", d32 | d8, 32'h0);

    // random traffic against the model
    for (int it = 0; it < 200; it++) begin
      r = $urandom_range(0, 9);
      if (r <= 7 && r >= 6) begin
        nw = $urandom;
        if ($urandom_range(0, 1) == 1) nw = pads ^ (32'h1 << $urandom_range(0, 31));
        pads = nw;
        model_pads(nw);
      end else begin
        if (r >= 8) off = A_ISTAT;
        else if ($urandom_range(0, 3) == 0) off = 8'($urandom_range(13, 63) * 4);
        else off = 8'($urandom_range(0, 12) * 4);
        addr = off | 8'($urandom_range(0, 3));
        size = 3'($urandom_range(0, 3));
        data = $urandom;
        wr(addr, size, data);
        model_write(addr, size, data);
      end
      repeat (6) tick();
      if ($urandom_range(0, 3) == 0) off = 8'($urandom_range(13, 63) * 4);
      else off = 8'($urandom_range(0, 12) * 4);
      rd(off | 8'($urandom_range(0, 3)), 3'($urandom_range(0, 3)), d32, d8);
      chk($sformatf("rnd_rd32_%02h", off), d32, model_read(off));
      chk($sformatf("rnd_rd8_%02h", off), d8, model_read(off) & 32'hFF);
      chk("rnd_do32", do32, m_do);
      chk("rnd_dir32", dir32, m_dir);
      chk("rnd_afc32", afc32, m_afc);
      chk("rnd_irq32", {31'h0, irq32}, {31'h0, |(m_istat & m_ie)});
      chk("rnd_pins8", {do8, dir8, afc8, 7'h0, irq8},
          {m_do[7:0], m_dir[7:0], m_afc[7:0], 7'h0, |(m_istat[7:0] & m_ie[7:0])});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
